// File: rtl/m_btb_2bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | m_btb_2bit: tagged direct-mapped branch target buffer with 2-bit         |
// | saturating direction counters, clear walk and update/miss statistics.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module m_btb_2bit #(
  parameter int         IDX_W     = 6,
  parameter int         PC_W      = 32,
  parameter logic [1:0] CTR_ALLOC = 2'b10
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_ce,
  input  logic            w_flush,
  input  logic [PC_W-1:0] w_lk_pc,
  output logic            w_lk_hit,
  output logic            w_lk_taken,
  output logic [PC_W-1:0] w_lk_tgt,
  input  logic            w_up_en,
  input  logic [PC_W-1:0] w_up_pc,
  input  logic            w_up_taken,
  input  logic [PC_W-1:0] w_up_tgt,
  input  logic            w_up_pred,
  output logic            w_busy,
  output logic [31:0]     w_n_upd,
  output logic [31:0]     w_n_miss
);

  localparam int ENTRIES = 2**IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ci, w_ci_nxt;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [PC_W-3:0]    r_tgt [ENTRIES];
  logic [1:0]         r_ctr [ENTRIES];
  logic [31:0]        r_n_upd, r_n_miss;

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  logic             w_lk_match, w_up_hit, w_up_acc;
  logic [1:0]       w_ctr_inc, w_ctr_dec;
  logic             w_unused;

  assign w_lk_idx = w_lk_pc[IDX_W+1:2];
  assign w_lk_tag = w_lk_pc[PC_W-1:IDX_W+2];
  assign w_up_idx = w_up_pc[IDX_W+1:2];
  assign w_up_tag = w_up_pc[PC_W-1:IDX_W+2];

  // Byte-offset bits carry no information for word-aligned branches.
  assign w_unused = ^{w_lk_pc[1:0], w_up_pc[1:0], w_up_tgt[1:0]};

  assign w_busy   = (r_state == S_CLEAR);
  assign w_n_upd  = r_n_upd;
  assign w_n_miss = r_n_miss;

  // Lookup is masked while the walk runs: stale valid bits are not yet cleared.
  assign w_lk_match = !w_busy && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_hit   = w_lk_match;
  assign w_lk_taken = w_lk_match && r_ctr[w_lk_idx][1];
  assign w_lk_tgt   = w_lk_match ? {r_tgt[w_lk_idx], 2'b00} : '0;

  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_acc = w_rst_n && w_ce && w_up_en && !w_flush && (r_state == S_RUN);

  assign w_ctr_inc = (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
  assign w_ctr_dec = (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_ci_nxt    = r_ci;
    if (w_flush) begin
      w_state_nxt = S_CLEAR;
      w_ci_nxt    = '0;
    end else if (r_state == S_CLEAR) begin
      w_ci_nxt = r_ci + 1'b1;
      if (r_ci == '1) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state  <= S_CLEAR;
      r_ci     <= '0;
      r_n_upd  <= '0;
      r_n_miss <= '0;
    end else if (w_ce) begin
      r_state <= w_state_nxt;
      r_ci    <= w_ci_nxt;
      if (w_up_acc) begin
        r_n_upd <= r_n_upd + 32'd1;
        if (w_up_pred != w_up_taken) begin
          r_n_miss <= r_n_miss + 32'd1;
        end
      end
    end
  end

  // Table storage has no reset; the clear walk invalidates it instead.
  always_ff @(posedge w_clk) begin
    if (w_rst_n && w_ce) begin
      if (r_state == S_CLEAR) begin
        r_valid[r_ci] <= 1'b0;
      end else if (w_up_acc) begin
        if (w_up_hit) begin
          if (w_up_taken) begin
            r_ctr[w_up_idx] <= w_ctr_inc;
            r_tgt[w_up_idx] <= w_up_tgt[PC_W-1:2];
          end else begin
            r_ctr[w_up_idx] <= w_ctr_dec;
          end
        end else if (w_up_taken) begin
          r_valid[w_up_idx] <= 1'b1;
          r_tag[w_up_idx]   <= w_up_tag;
          r_tgt[w_up_idx]   <= w_up_tgt[PC_W-1:2];
          r_ctr[w_up_idx]   <= CTR_ALLOC;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_btb_2bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_m_btb_2bit: directed vectors, clear/flush sequences and random        |
// | stimulus against a behavioural BTB model.                                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_m_btb_2bit;

  localparam int IDX_W = 4;
  localparam int PC_W  = 32;
  localparam int ENT   = 16;

  logic        r_clk = 1'b0;
  logic        r_rst_n, r_ce, r_flush, r_up_en, r_up_taken, r_up_pred;
  logic [31:0] r_lk_pc, r_up_pc, r_up_tgt;
  logic        w_lk_hit, w_lk_taken, w_busy;
  logic [31:0] w_lk_tgt, w_n_upd, w_n_miss;

  always #5 r_clk = ~r_clk;

  m_btb_2bit #(.IDX_W(IDX_W), .PC_W(PC_W), .CTR_ALLOC(2'b10)) dut (
    .w_clk(r_clk), .w_rst_n(r_rst_n), .w_ce(r_ce), .w_flush(r_flush),
    .w_lk_pc(r_lk_pc), .w_lk_hit(w_lk_hit), .w_lk_taken(w_lk_taken), .w_lk_tgt(w_lk_tgt),
    .w_up_en(r_up_en), .w_up_pc(r_up_pc), .w_up_taken(r_up_taken), .w_up_tgt(r_up_tgt),
    .w_up_pred(r_up_pred), .w_busy(w_busy), .w_n_upd(w_n_upd), .w_n_miss(w_n_miss)
  );

  // Reference model: a table of records plus a count of clear cycles left.
  bit          m_val [ENT];
  logic [31:0] m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_ctr [ENT];
  int          m_busy_left = ENT;
  logic [31:0] m_upd = 0, m_miss = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  task automatic m_look(input logic [31:0] pc, output bit hit, output bit tk, output logic [31:0] tgt);
    int i;
    i   = m_index(pc);
    hit = (m_busy_left == 0) && m_val[i] && (m_tag[i] == (pc / 64));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = hit ? m_tgt[i] : 32'd0;
  endtask

  task automatic m_invalidate();
    for (int i = 0; i < ENT; i++) m_val[i] = 1'b0;
  endtask

  task automatic m_step();
    int  i;
    bit  hit;
    if (!r_rst_n) begin
      m_busy_left = ENT;
      m_invalidate();
      m_upd  = 0;
      m_miss = 0;
    end else if (r_ce) begin
      if (r_flush) begin
        m_busy_left = ENT;
        m_invalidate();
      end else if (m_busy_left > 0) begin
        m_busy_left--;
      end else if (r_up_en) begin
        i   = m_index(r_up_pc);
        hit = m_val[i] && (m_tag[i] == (r_up_pc / 64));
        if (hit && r_up_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = r_up_tgt & ~32'h3;
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (r_up_taken) begin
          m_val[i] = 1'b1;
          m_tag[i] = r_up_pc / 64;
          m_tgt[i] = r_up_tgt & ~32'h3;
          m_ctr[i] = 2;
        end
        m_upd = m_upd + 1;
        if (r_up_pred != r_up_taken) m_miss = m_miss + 1;
      end
    end
  endtask

  // One clock: check lookup before the edge, then state after it.
  task automatic cycle(input bit do_lk);
    bit          h, t;
    logic [31:0] g;
    #1;
    if (do_lk) begin
      m_look(r_lk_pc, h, t, g);
      chk("lk_hit", {31'd0, w_lk_hit}, {31'd0, h});
      chk("lk_taken", {31'd0, w_lk_taken}, {31'd0, t});
      chk("lk_tgt", w_lk_tgt, g);
    end
    @(posedge r_clk);
    m_step();
    #1;
    chk("busy", {31'd0, w_busy}, {31'd0, (m_busy_left > 0)});
    chk("n_upd", w_n_upd, m_upd);
    chk("n_miss", w_n_miss, m_miss);
  endtask

  typedef struct {
    bit          ce;
    logic [31:0] lk;
    bit          en;
    logic [31:0] pc;
    bit          tk;
    logic [31:0] tg;
    bit          pr;
    bit          e_hit;
    bit          e_tk;
    logic [31:0] e_tgt;
    logic [31:0] e_upd;
    logic [31:0] e_miss;
  } vec_t;

  function automatic vec_t v(bit ce, logic [31:0] lk, bit en, logic [31:0] pc, bit tk,
                             logic [31:0] tg, bit pr, bit eh, bit et, logic [31:0] eg,
                             logic [31:0] eu, logic [31:0] em);
    vec_t r;
    r.ce = ce; r.lk = lk; r.en = en; r.pc = pc; r.tk = tk; r.tg = tg; r.pr = pr;
    r.e_hit = eh; r.e_tk = et; r.e_tgt = eg; r.e_upd = eu; r.e_miss = em;
    return r;
  endfunction

  task automatic idle_inputs();
    r_ce = 1'b1; r_flush = 1'b0; r_up_en = 1'b0; r_up_taken = 1'b0;
    r_up_pred = 1'b0; r_up_pc = '0; r_up_tgt = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [21];
    int   cnt;

    tv[0]  = v(1, 'h40,  1, 'h40,  1, 'h100, 1, 0, 0, 'h0,   1,  0);
    tv[1]  = v(1, 'h40,  0, 'h0,   0, 'h0,   0, 1, 1, 'h100, 1,  0);
    tv[2]  = v(1, 'h440, 0, 'h0,   0, 'h0,   0, 0, 0, 'h0,   1,  0);
    tv[3]  = v(1, 'h40,  1, 'h40,  1, 'h100, 1, 1, 1, 'h100, 2,  0);
    tv[4]  = v(1, 'h40,  1, 'h40,  1, 'h100, 1, 1, 1, 'h100, 3,  0);
    tv[5]  = v(1, 'h40,  1, 'h40,  0, 'h200, 0, 1, 1, 'h100, 4,  0);
    tv[6]  = v(1, 'h40,  1, 'h40,  0, 'h200, 0, 1, 1, 'h100, 5,  0);
    tv[7]  = v(1, 'h40,  1, 'h40,  0, 'h200, 0, 1, 0, 'h100, 6,  0);
    tv[8]  = v(1, 'h40,  1, 'h40,  0, 'h200, 0, 1, 0, 'h100, 7,  0);
    tv[9]  = v(1, 'h40,  0, 'h0,   0, 'h0,   0, 1, 0, 'h100, 7,  0);
    tv[10] = v(1, 'h80,  1, 'h80,  0, 'h0,   0, 0, 0, 'h0,   8,  0);
    tv[11] = v(1, 'h80,  1, 'h80,  1, 'h20,  1, 0, 0, 'h0,   9,  0);
    tv[12] = v(1, 'h80,  1, 'h880, 1, 'h60,  1, 1, 1, 'h20,  10, 0);
    tv[13] = v(1, 'h80,  0, 'h0,   0, 'h0,   0, 0, 0, 'h0,   10, 0);
    tv[14] = v(1, 'h880, 0, 'h0,   0, 'h0,   0, 1, 1, 'h60,  10, 0);
    tv[15] = v(1, 'h104, 1, 'h104, 1, 'h300, 1, 0, 0, 'h0,   11, 0);
    tv[16] = v(1, 'h104, 1, 'h104, 1, 'h300, 0, 1, 1, 'h300, 12, 1);
    tv[17] = v(1, 'h104, 1, 'h104, 0, 'h300, 1, 1, 1, 'h300, 13, 2);
    tv[18] = v(1, 'h104, 1, 'h104, 1, 'h300, 1, 1, 1, 'h300, 14, 2);
    tv[19] = v(0, 'h104, 1, 'h104, 1, 'h500, 0, 1, 1, 'h300, 14, 2);
    tv[20] = v(1, 'h107, 0, 'h0,   0, 'h0,   0, 1, 1, 'h300, 14, 2);

    // Reset held for three cycles; outputs are undefined before the first edge.
    idle_inputs();
    r_rst_n = 1'b0;
    r_lk_pc = 32'h40;
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    chk("rst_busy", {31'd0, w_busy}, 32'd1);
    chk("rst_n_upd", w_n_upd, 32'd0);

    // Clear walk length after release; lookups must miss throughout.
    r_rst_n = 1'b1;
    cnt = 0;
    while (w_busy && cnt < 40) begin
      r_lk_pc = $urandom;
      #1;
      chk("clr_hit", {31'd0, w_lk_hit}, 32'd0);
      chk("clr_tgt", w_lk_tgt, 32'd0);
      cycle(1'b1);
      cnt++;
    end
    chk("clear_len", cnt, 32'd16);
    chk("clear_n_upd", w_n_upd, 32'd0);

    for (int k = 0; k < 21; k++) begin
      r_ce = tv[k].ce; r_lk_pc = tv[k].lk; r_up_en = tv[k].en; r_up_pc = tv[k].pc;
      r_up_taken = tv[k].tk; r_up_tgt = tv[k].tg; r_up_pred = tv[k].pr;
      #1;
      chk($sformatf("v%0d_hit", k), {31'd0, w_lk_hit}, {31'd0, tv[k].e_hit});
      chk($sformatf("v%0d_taken", k), {31'd0, w_lk_taken}, {31'd0, tv[k].e_tk});
      chk($sformatf("v%0d_tgt", k), w_lk_tgt, tv[k].e_tgt);
      cycle(1'b1);
      chk($sformatf("v%0d_upd", k), w_n_upd, tv[k].e_upd);
      chk($sformatf("v%0d_miss", k), w_n_miss, tv[k].e_miss);
      chk($sformatf("v%0d_busy", k), {31'd0, w_busy}, 32'd0);
    end

    // Flush alongside an update: update dropped, walk starts.
    idle_inputs();
    r_flush = 1'b1; r_up_en = 1'b1; r_up_pc = 32'h104; r_up_taken = 1'b1;
    r_up_tgt = 32'h700; r_up_pred = 1'b0; r_lk_pc = 32'h104;
    cycle(1'b1);
    chk("fl_busy", {31'd0, w_busy}, 32'd1);
    chk("fl_upd", w_n_upd, 32'd14);
    chk("fl_miss", w_n_miss, 32'd2);
    idle_inputs();
    repeat (5) cycle(1'b1);
    chk("fl_mid_busy", {31'd0, w_busy}, 32'd1);
    r_flush = 1'b1;
    cycle(1'b1);
    r_flush = 1'b0;
    cnt = 0;
    while (w_busy && cnt < 40) begin
      cycle(1'b1);
      cnt++;
    end
    chk("reflush_len", cnt, 32'd16);
    foreach (tv[k]) begin
      if (k < 3) begin
        r_lk_pc = (k == 0) ? 32'h104 : (k == 1) ? 32'h880 : 32'h40;
        #1;
        chk("post_fl_hit", {31'd0, w_lk_hit}, 32'd0);
      end
    end
    chk("post_fl_upd", w_n_upd, 32'd14);
    chk("post_fl_miss", w_n_miss, 32'd2);

    // Random traffic over a small PC pool so hits, aliasing and replacement occur.
    for (int n = 0; n < 3000; n++) begin
      r_rst_n    = ($urandom_range(0, 399) != 0);
      r_ce       = ($urandom_range(0, 9) != 0);
      r_flush    = ($urandom_range(0, 199) == 0);
      r_up_en    = $urandom_range(0, 1) == 1;
      r_up_pc    = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom)};
      r_up_taken = $urandom_range(0, 2) != 0;
      r_up_pred  = $urandom_range(0, 1) == 1;
      r_up_tgt   = $urandom;
      r_lk_pc    = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom)};
      cycle(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
